// File: rtl/snake_pkg.sv
// Shared types for the snake engine: direction codes,
// reversal test and the pixel-to-cell position bundle.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  localparam int PIX_W = 12;

  typedef struct packed {
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
  } pix_pos_t;

  // Opposite directions differ only in bit 0.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return {a[1], ~a[0]} == b;
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// One cell-vs-segment equality compare, gated by
// whether that segment slot is live.
module snake_cell_match #(
  parameter int XW = 7,
  parameter int YW = 6
) (
  input  logic [XW-1:0] ax,
  input  logic [YW-1:0] ay,
  input  logic [XW-1:0] bx,
  input  logic [YW-1:0] by,
  input  logic          live,
  output logic          hit
);

  assign hit = live & (ax == bx) & (ay == by);

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: segment shift array, direction and
// grow latching, wall/self collision, pixel hit query.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W    = 80,
  parameter int GRID_H    = 60,
  parameter int CELL_LOG2 = 3,
  parameter int MAX_LEN   = 32,
  parameter int INIT_LEN  = 4,
  parameter int INIT_X    = 10,
  parameter int INIT_Y    = 30,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          pause,
  input  logic          dir_valid,
  input  logic [1:0]    dir_in,
  input  logic          grow,
  input  logic [11:0]   pix_x,
  input  logic [11:0]   pix_y,
  output logic          pix_head,
  output logic          pix_body,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          dead,
  output logic          moved
);

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_q;
  dir_t          cur_dir;
  dir_t          pend_dir;
  dir_t          req_dir;
  logic          grow_pend;
  logic          dead_q;
  logic          moved_q;

  logic          fire;
  logic          grow_eff;
  logic          wall;
  logic          self_hit;
  logic          ok;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [LW-1:0] grow_inc;
  logic [LW-1:0] col_lim;

  logic [MAX_LEN-1:0] col_live;
  logic [MAX_LEN-1:0] col_hit;
  logic [MAX_LEN-1:0] pix_live;
  logic [MAX_LEN-1:0] pix_hit;

  pix_pos_t      pcell;
  logic          in_range;

  assign req_dir  = dir_t'(dir_in);
  assign fire     = step & ~pause & ~dead_q;
  assign grow_eff = (grow_pend | grow)
                  & (len_q < LW'(MAX_LEN));
  assign grow_inc = {{(LW-1){1'b0}}, grow_eff};

  // The tail slot vacates on a plain move, so it only
  // blocks the head when this move also lengthens.
  assign col_lim  = len_q + grow_inc - LW'(1);

  // Next head cell and wall test for the pending direction.
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    unique case (pend_dir)
      DIR_RIGHT: begin
        wall = (seg_x[0] == XW'(GRID_W - 1));
        nx   = seg_x[0] + XW'(1);
      end
      DIR_LEFT: begin
        wall = (seg_x[0] == '0);
        nx   = seg_x[0] - XW'(1);
      end
      DIR_DOWN: begin
        wall = (seg_y[0] == YW'(GRID_H - 1));
        ny   = seg_y[0] + YW'(1);
      end
      DIR_UP: begin
        wall = (seg_y[0] == '0);
        ny   = seg_y[0] - YW'(1);
      end
    endcase
  end

  assign pcell.x  = pix_x >> CELL_LOG2;
  assign pcell.y  = pix_y >> CELL_LOG2;
  assign in_range = (pcell.x < PIX_W'(GRID_W))
                  & (pcell.y < PIX_W'(GRID_H));

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_match
    assign col_live[i] = (LW'(i) < col_lim);
    assign pix_live[i] = (LW'(i) < len_q);

    snake_cell_match #(.XW(XW), .YW(YW)) u_col (
      .ax   (nx),
      .ay   (ny),
      .bx   (seg_x[i]),
      .by   (seg_y[i]),
      .live (col_live[i]),
      .hit  (col_hit[i])
    );

    snake_cell_match #(.XW(XW), .YW(YW)) u_pix (
      .ax   (pcell.x[XW-1:0]),
      .ay   (pcell.y[YW-1:0]),
      .bx   (seg_x[i]),
      .by   (seg_y[i]),
      .live (pix_live[i]),
      .hit  (pix_hit[i])
    );
  end

  assign self_hit = |col_hit;
  assign ok       = fire & ~wall & ~self_hit;

  // Segment array: load the initial line, shift on a move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(INIT_Y) : '0;
      end
    end else if (ok) begin
      for (int i = MAX_LEN - 1; i >= 1; i--) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
      seg_x[0] <= nx;
      seg_y[0] <= ny;
    end
  end

  // Length, direction, grow request and death tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= LW'(INIT_LEN);
      cur_dir   <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      grow_pend <= 1'b0;
      dead_q    <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      moved_q <= ok;
      if (ok) begin
        len_q   <= len_q + grow_inc;
        cur_dir <= pend_dir;
      end
      if (fire & (wall | self_hit))
        dead_q <= 1'b1;
      if (ok)
        grow_pend <= 1'b0;
      else if (grow & ~dead_q)
        grow_pend <= 1'b1;
      if (dir_valid & ~dead_q
          & ~is_reverse(req_dir, cur_dir))
        pend_dir <= req_dir;
    end
  end

  // Registered pixel query for the renderer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_head <= 1'b0;
      pix_body <= 1'b0;
    end else begin
      pix_head <= in_range & pix_hit[0];
      pix_body <= in_range & ~pix_hit[0]
                & (|pix_hit[MAX_LEN-1:1]);
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_q;
  assign dead   = dead_q;
  assign moved  = moved_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: stimulus pushes expected
// moves/states/pixel answers, a monitor pops and compares.
module tb_snake_engine;
  import snake_pkg::*;

  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        pause = 1'b0;
  logic        dir_valid = 1'b0;
  logic [1:0]  dir_in = 2'd0;
  logic        grow = 1'b0;
  logic [11:0] pix_x = 12'hfff;
  logic [11:0] pix_y = 12'hfff;
  logic        pix_head;
  logic        pix_body;
  logic [6:0]  head_x;
  logic [5:0]  head_y;
  logic [3:0]  length;
  logic        dead;
  logic        moved;

  logic probe = 1'b0;
  logic pix_req = 1'b0;
  logic pix_req_d = 1'b0;

  int compared = 0;
  int mismatched = 0;

  typedef struct { int hx; int hy; int len; } mv_t;
  typedef struct { int hx; int hy; int len; int dd; } st_t;
  typedef struct { int h; int b; } px_t;

  mv_t mq[$];
  st_t sq[$];
  px_t pq[$];

  snake_engine #(.MAX_LEN(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .pause     (pause),
    .dir_valid (dir_valid),
    .dir_in    (dir_in),
    .grow      (grow),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_head  (pix_head),
    .pix_body  (pix_body),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .dead      (dead),
    .moved     (moved)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pix_req_d <= pix_req;

  // Monitor: compare whatever the DUT presents this cycle.
  always @(negedge clk) begin
    mv_t m;
    st_t s;
    px_t p;
    if (moved) begin
      compared++;
      if (mq.size() == 0) begin
        mismatched++;
        $display("FAIL move_unexpected got (%0d,%0d) len %0d",
                 head_x, head_y, length);
      end else begin
        m = mq.pop_front();
        if (head_x != m.hx || head_y != m.hy || length != m.len) begin
          mismatched++;
          $display("FAIL move got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                   head_x, head_y, length, m.hx, m.hy, m.len);
        end
      end
    end
    if (probe) begin
      compared++;
      s = sq.pop_front();
      if (head_x != s.hx || head_y != s.hy || length != s.len
          || dead != s.dd[0] || pix_head || pix_body) begin
        mismatched++;
        $display("FAIL state got (%0d,%0d) len %0d dead %0d pix %0d%0d want (%0d,%0d) len %0d dead %0d pix 00",
                 head_x, head_y, length, dead, pix_head, pix_body,
                 s.hx, s.hy, s.len, s.dd);
      end
    end
    if (pix_req_d) begin
      compared++;
      p = pq.pop_front();
      if (pix_head != p.h[0] || pix_body != p.b[0]) begin
        mismatched++;
        $display("FAIL pixel got head %0d body %0d want head %0d body %0d",
                 pix_head, pix_body, p.h, p.b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mv(input int hx, input int hy, input int len,
                    input logic g);
    mq.push_back('{hx, hy, len});
    step = 1'b1;
    grow = g;
    cyc();
    step = 1'b0;
    grow = 1'b0;
  endtask

  task automatic nomove(input logic g);
    step = 1'b1;
    grow = g;
    cyc();
    step = 1'b0;
    grow = 1'b0;
  endtask

  task automatic press(input dir_t d);
    dir_valid = 1'b1;
    dir_in = d;
    cyc();
    dir_valid = 1'b0;
  endtask

  task automatic chk(input int hx, input int hy, input int len,
                     input int dd);
    sq.push_back('{hx, hy, len, dd});
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic query(input int px, input int py,
                       input int h, input int b);
    pq.push_back('{h, b});
    pix_x = 12'(px);
    pix_y = 12'(py);
    pix_req = 1'b1;
    cyc();
    pix_req = 1'b0;
    pix_x = 12'hfff;
    pix_y = 12'hfff;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    chk(10, 30, 4, 0);
    rst_n = 1'b1;
    pix_x = 12'hfff;
    pix_y = 12'hfff;
  endtask

  initial begin
    do_reset();

    // 1: three plain steps to the right
    mv(11, 30, 4, 0);
    mv(12, 30, 4, 0);
    mv(13, 30, 4, 0);
    chk(13, 30, 4, 0);
    query(13 * 8, 30 * 8, 1, 0);
    query(10 * 8 + 3, 30 * 8 + 7, 0, 1);
    query(9 * 8, 30 * 8, 0, 0);

    // 2: reversal ignored, then turn down
    press(DIR_LEFT);
    mv(14, 30, 4, 0);
    press(DIR_DOWN);
    mv(14, 31, 4, 0);

    // 3: growth, including saturation at ML
    mv(14, 32, 5, 1);
    query(12 * 8, 30 * 8, 0, 1);
    grow = 1'b1;
    cyc();
    grow = 1'b0;
    mv(14, 33, 6, 0);
    mv(14, 34, 7, 1);
    mv(14, 35, 8, 1);
    mv(14, 36, 8, 1);
    mv(14, 37, 8, 0);
    chk(14, 37, 8, 0);

    // pause holds the snake
    pause = 1'b1;
    nomove(0);
    pause = 1'b0;
    chk(14, 37, 8, 0);

    // 4: run into the right wall
    press(DIR_RIGHT);
    for (int x = 15; x <= 79; x++) mv(x, 37, 8, 0);
    nomove(0);
    chk(79, 37, 8, 1);
    press(DIR_UP);
    nomove(1);
    nomove(0);
    chk(79, 37, 8, 1);
    query(78 * 8, 37 * 8, 0, 1);
    query(79 * 8, 37 * 8, 1, 0);

    // 6: out-of-range pixels, incl. one that aliases head
    query(80 * 8, 37 * 8, 0, 0);
    query((128 + 79) * 8, 37 * 8, 0, 0);
    query(79 * 8, 60 * 8, 0, 0);

    // mid-run reset with the pixel on the old head
    pix_x = 12'(79 * 8);
    pix_y = 12'(37 * 8);
    do_reset();

    // 5a: length 5 loop bites the body
    mv(11, 30, 5, 1);
    press(DIR_DOWN);
    mv(11, 31, 5, 0);
    press(DIR_LEFT);
    mv(10, 31, 5, 0);
    press(DIR_UP);
    nomove(0);
    chk(10, 31, 5, 1);

    // 5b: length 4 loop chases its vacating tail
    do_reset();
    press(DIR_DOWN);
    mv(10, 31, 4, 0);
    press(DIR_LEFT);
    mv(9, 31, 4, 0);
    press(DIR_UP);
    mv(9, 30, 4, 0);
    chk(9, 30, 4, 0);

    // 5c: same loop but growing, so the tail stays
    do_reset();
    press(DIR_DOWN);
    mv(10, 31, 4, 0);
    press(DIR_LEFT);
    mv(9, 31, 4, 0);
    press(DIR_UP);
    nomove(1);
    chk(9, 31, 4, 1);

    // concurrent dir with step applies to the following step
    do_reset();
    dir_valid = 1'b1;
    dir_in = DIR_DOWN;
    mv(11, 30, 4, 0);
    dir_valid = 1'b0;
    mv(11, 31, 4, 0);

    repeat (3) cyc();
    compared++;
    if (mq.size() != 0 || sq.size() != 0 || pq.size() != 0) begin
      mismatched++;
      $display("FAIL leftover got %0d/%0d/%0d want 0/0/0",
               mq.size(), sq.size(), pq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
